o_feature_store: RTL and testbench

// - Output-feature writeback engine, the store-side counterpart of the input/weight fetch units.
// - On an instruction pulse from top_fsm it reads a run of words from the on-chip output-feature buffer.
// - Each word is written to external memory over a valid/ready write port.
// - Pulses store_done when the last word has been accepted by the external side.

---
 rtl/tproc_pkg.sv | 24 ++
 rtl/store_skid_fifo.sv | 55 +++++
 rtl/o_feature_store.sv | 153 +++++++++++++++
 tb/tb_o_feature_store.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tproc_pkg.sv
// rtl/tproc_pkg.sv - shared widths, instruction field offsets and FSM encodings for the tensor processor
package tproc_pkg;
    localparam int DATA_W     = 128;
    localparam int BUF_ADDR_W = 15;
    localparam int EXT_ADDR_W = 16;
    localparam int LEN_W      = 8;
    localparam int BUF_RD_LAT = 2;

    // Store-instruction field positions, kept in step with the instruction parser
    localparam int         OPC_LSB    = 0;
    localparam int         OPC_W      = 4;
    localparam int         MEMSEL_LSB = 4;
    localparam int         LEN_LSB    = 12;
    localparam int         SRC_LSB    = 20;
    localparam int         DST_LSB    = 35;
    localparam logic [3:0] OPC_STORE  = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } st_store_e;
endpackage

// File: rtl/store_skid_fifo.sv
// rtl/store_skid_fifo.sv - small synchronous FIFO absorbing buffer read returns under write backpressure
module store_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/o_feature_store.sv
// rtl/o_feature_store.sv - output-feature writeback: on-chip buffer reads streamed to an external write port
module o_feature_store #(
    parameter int DATA_W     = tproc_pkg::DATA_W,
    parameter int BUF_ADDR_W = tproc_pkg::BUF_ADDR_W,
    parameter int EXT_ADDR_W = tproc_pkg::EXT_ADDR_W,
    parameter int LEN_W      = tproc_pkg::LEN_W,
    parameter int BUF_RD_LAT = tproc_pkg::BUF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_enable,
    input  logic [BUF_ADDR_W-1:0] src_addr,
    input  logic [EXT_ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]      store_len,
    input  logic [7:0]            mem_sel,
    output logic                  buf_rd_en,
    output logic [BUF_ADDR_W-1:0] buf_rd_addr,
    output logic                  buf_bank_sel,
    input  logic [DATA_W-1:0]     buf_rd_data,
    output logic                  ext_wr_en,
    output logic [EXT_ADDR_W-1:0] ext_wr_addr,
    output logic [DATA_W-1:0]     ext_wr_data,
    input  logic                  ext_wr_ready,
    output logic                  busy,
    output logic                  store_done
);
    import tproc_pkg::*;

    localparam int FIFO_DEPTH = BUF_RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = CNT_W + 1;
    localparam int IDX_W      = LEN_W + 1;

    st_store_e             r_state;
    st_store_e             w_state_nxt;
    logic [BUF_ADDR_W-1:0] r_src;
    logic [EXT_ADDR_W-1:0] r_dst;
    logic [IDX_W-1:0]      r_len;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [IDX_W-1:0]      r_wr_idx;
    logic                  r_bank;
    logic [BUF_RD_LAT-1:0] r_vld;

    logic                  w_rd_en;
    logic                  w_done;
    logic [SUM_W-1:0]      w_in_flight;
    logic                  w_credit_ok;
    logic                  w_ret;
    logic                  w_wr_en;
    logic                  w_accept;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [DATA_W-1:0]     w_fifo_dout;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_unused;

    assign w_unused = ^{mem_sel[7:1], w_fifo_full};

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < BUF_RD_LAT; i++) begin
            w_in_flight = w_in_flight + SUM_W'(r_vld[i]);
        end
    end

    // Issue only while every outstanding read is guaranteed a FIFO slot
    assign w_credit_ok = (w_in_flight + SUM_W'(w_fifo_count)) < SUM_W'(FIFO_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (store_enable) w_state_nxt = (store_len == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_credit_ok) begin
                    w_rd_en = 1'b1;
                    if (r_rd_idx == r_len - IDX_W'(1)) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_wr_idx == r_len) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A returning word goes straight to the write port when nothing is queued ahead of it
    assign w_ret       = r_vld[BUF_RD_LAT-1];
    assign w_wr_en     = !w_fifo_empty || w_ret;
    assign w_accept    = w_wr_en && ext_wr_ready;
    assign w_fifo_pop  = !w_fifo_empty && w_accept;
    assign w_fifo_push = w_ret && !(w_fifo_empty && w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_bank   <= 1'b0;
            r_vld    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= (r_vld << 1) | BUF_RD_LAT'(w_rd_en);
            if (r_state == ST_IDLE && store_enable) begin
                r_src    <= src_addr;
                r_dst    <= dst_addr;
                r_len    <= {1'b0, store_len};
                r_bank   <= mem_sel[0];
                r_rd_idx <= '0;
                r_wr_idx <= '0;
            end else begin
                if (w_rd_en)  r_rd_idx <= r_rd_idx + IDX_W'(1);
                if (w_accept) r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
        end
    end

    store_skid_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (buf_rd_data),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    assign buf_rd_en    = w_rd_en;
    assign buf_rd_addr  = r_src + BUF_ADDR_W'(r_rd_idx);
    assign buf_bank_sel = r_bank;
    assign ext_wr_en    = w_wr_en;
    assign ext_wr_addr  = r_dst + EXT_ADDR_W'(r_wr_idx);
    assign ext_wr_data  = !w_fifo_empty ? w_fifo_dout : (w_ret ? buf_rd_data : '0);
    assign busy         = (r_state != ST_IDLE);
    assign store_done   = w_done;
endmodule

// File: tb/tb_o_feature_store.sv
// tb/tb_o_feature_store.sv - scoreboard bench for o_feature_store
module tb_o_feature_store;
    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         store_enable;
    logic [14:0]  src_addr;
    logic [15:0]  dst_addr;
    logic [7:0]   store_len;
    logic [7:0]   mem_sel;
    logic         buf_rd_en;
    logic [14:0]  buf_rd_addr;
    logic         buf_bank_sel;
    logic [127:0] buf_rd_data;
    logic         ext_wr_en;
    logic [15:0]  ext_wr_addr;
    logic [127:0] ext_wr_data;
    logic         ext_wr_ready;
    logic         busy;
    logic         store_done;

    logic [127:0] r_stage1;
    beat_t        sb[$];
    logic [14:0]  rd_addrs[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         stall_q = 1'b0;
    logic [15:0]  stall_addr;
    logic [127:0] stall_data;

    o_feature_store dut (
        .clk          (clk),
        .rst          (rst),
        .store_enable (store_enable),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .store_len    (store_len),
        .mem_sel      (mem_sel),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_bank_sel (buf_bank_sel),
        .buf_rd_data  (buf_rd_data),
        .ext_wr_en    (ext_wr_en),
        .ext_wr_addr  (ext_wr_addr),
        .ext_wr_data  (ext_wr_data),
        .ext_wr_ready (ext_wr_ready),
        .busy         (busy),
        .store_done   (store_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] buf_word(input logic [14:0] a);
        return {16'hC0DE, 1'b0, a, ~{17'b0, a}, {17'b0, a} * 32'd3, 32'hF00D0000 ^ {17'b0, a}};
    endfunction

    // Two-cycle buffer read model
    always @(posedge clk) begin
        r_stage1    <= buf_rd_en ? buf_word(buf_rd_addr) : '0;
        buf_rd_data <= r_stage1;
    end

    // Write-port monitor: hold stability under backpressure and in-order scoreboard match
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_tests++;
                if (!ext_wr_en || ext_wr_addr !== stall_addr || ext_wr_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL hold: en=%b addr=%h data=%h, required en=1 addr=%h data=%h",
                             ext_wr_en, ext_wr_addr, ext_wr_data, stall_addr, stall_data);
                end
            end
            if (ext_wr_en && ext_wr_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: addr=%h data=%h, required no beat", ext_wr_addr, ext_wr_data);
                end else begin
                    beat_t exp_b;
                    exp_b = sb.pop_front();
                    if (ext_wr_addr !== exp_b.addr || ext_wr_data !== exp_b.data) begin
                        n_fail++;
                        $display("FAIL beat: addr=%h data=%h, required addr=%h data=%h",
                                 ext_wr_addr, ext_wr_data, exp_b.addr, exp_b.data);
                    end
                end
            end
            stall_q    = ext_wr_en && !ext_wr_ready;
            stall_addr = ext_wr_addr;
            stall_data = ext_wr_data;
        end
    end

    // Caller is 1 time unit after a rising edge; returns likewise in the cycle after the start pulse
    task automatic start_store(input logic [14:0] s, input logic [15:0] d, input logic [7:0] l,
                               input logic [7:0] ms);
        beat_t b;
        src_addr     = s;
        dst_addr     = d;
        store_len    = l;
        mem_sel      = ms;
        store_enable = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            b.addr = d + 16'(i);
            b.data = buf_word(s + 15'(i));
            sb.push_back(b);
        end
        @(posedge clk); #1;
        store_enable = 1'b0;
    endtask

    task automatic run_store(input logic [14:0] s, input logic [15:0] d, input logic [7:0] l,
                             input logic [7:0] ms, input int mode,
                             output int first_wr, output int last_beat, output int done_c,
                             output int n_done, output int n_rd, output int n_busy,
                             output logic busy_after);
        first_wr = -1; last_beat = -1; done_c = -1;
        n_done = 0; n_rd = 0; n_busy = 0; busy_after = 1'b1;
        rd_addrs.delete();
        start_store(s, d, l, ms);
        for (int c = 1; c <= 300; c++) begin
            ext_wr_ready = (mode == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
            @(negedge clk);
            if (ext_wr_en && first_wr < 0) first_wr = c;
            if (ext_wr_en && ext_wr_ready) last_beat = c;
            if (buf_rd_en) begin
                n_rd++;
                rd_addrs.push_back(buf_rd_addr);
            end
            if (busy) n_busy++;
            if (store_done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                busy_after = busy;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        ext_wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, store_done, buf_rd_en, ext_wr_en, buf_bank_sel, buf_rd_addr, ext_wr_addr, ext_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b, required all 0",
                     busy, store_done, buf_rd_en, ext_wr_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int fw, lb, dc, nd, nr, nb;
        logic ba;
        run_store(15'h0010, 16'h0200, 8'd4, 8'h01, 0, fw, lb, dc, nd, nr, nb, ba);
        n_tests++; if (fw !== 3) begin n_fail++; $display("FAIL basic_first_wr: got %0d required 3", fw); end
        n_tests++; if (lb !== 6) begin n_fail++; $display("FAIL basic_last_beat: got %0d required 6", lb); end
        n_tests++; if (dc !== lb + 2) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required %0d", dc, lb + 2); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", nd); end
        n_tests++; if (nr !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d required 4", nr); end
        n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL basic_missing: got %0d left required 0", sb.size()); end
        n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b required 0", ba); end
        n_tests++; if (buf_bank_sel !== 1'b1) begin n_fail++; $display("FAIL basic_bank: got %b required 1", buf_bank_sel); end
        sb.delete();
    endtask

    task automatic test_backpressure();
        int fw, lb, dc, nd, nr, nb;
        logic ba;
        run_store(15'h0400, 16'h1000, 8'd8, 8'h00, 1, fw, lb, dc, nd, nr, nb, ba);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d required 1", nd); end
        n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL bp_missing: got %0d left required 0", sb.size()); end
        n_tests++; if (nr !== 8) begin n_fail++; $display("FAIL bp_reads: got %0d required 8", nr); end
        n_tests++; if (dc !== lb + 2) begin n_fail++; $display("FAIL bp_done_cycle: got %0d required %0d", dc, lb + 2); end
        n_tests++; if (buf_bank_sel !== 1'b0) begin n_fail++; $display("FAIL bp_bank: got %b required 0", buf_bank_sel); end
        sb.delete();
    endtask

    task automatic test_zero_len();
        int fw, lb, dc, nd, nr, nb;
        logic ba;
        run_store(15'h0010, 16'h0200, 8'd0, 8'h00, 0, fw, lb, dc, nd, nr, nb, ba);
        n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d required 0", nr); end
        n_tests++; if (fw !== -1) begin n_fail++; $display("FAIL zero_writes: first wr_en at %0d required none", fw); end
        n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 1", dc); end
        n_tests++; if (nb !== 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d required 1", nb); end
        sb.delete();
    endtask

    task automatic test_wrap();
        int fw, lb, dc, nd, nr, nb;
        logic ba;
        logic [14:0] exp_rd [3];
        exp_rd[0] = 15'h7FFE; exp_rd[1] = 15'h7FFF; exp_rd[2] = 15'h0000;
        run_store(15'h7FFE, 16'hFFFF, 8'd3, 8'h00, 0, fw, lb, dc, nd, nr, nb, ba);
        n_tests++;
        if (rd_addrs.size() !== 3) begin
            n_fail++;
            $display("FAIL wrap_read_count: got %0d required 3", rd_addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (rd_addrs[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL wrap_rd_addr[%0d]: got %h required %h", i, rd_addrs[i], exp_rd[i]);
                end
            end
        end
        n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL wrap_missing: got %0d left required 0", sb.size()); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d required 1", nd); end
        sb.delete();
    endtask

    task automatic test_start_busy_reset();
        int beats, n_done, n_bad, fw, lb, dc, nd, nr, nb;
        logic ba;
        beats = 0; n_done = 0; n_bad = 0;
        start_store(15'h0100, 16'h3000, 8'd16, 8'hFF);
        for (int c = 1; c <= 100 && beats < 5; c++) begin
            ext_wr_ready = 1'b1;
            if (c == 3) begin
                src_addr = 15'h5555; dst_addr = 16'h7777; store_len = 8'd2; store_enable = 1'b1;
            end else begin
                store_enable = 1'b0;
            end
            @(negedge clk);
            if (ext_wr_en && ext_wr_ready) beats++;
            if (store_done) n_done++;
            @(posedge clk); #1;
        end
        store_enable = 1'b0;
        n_tests++; if (beats !== 5) begin n_fail++; $display("FAIL busy_beats: got %0d required 5", beats); end
        rst = 1'b1;
        ext_wr_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_tests++;
        if ({busy, store_done, buf_rd_en, ext_wr_en, buf_bank_sel, buf_rd_addr, ext_wr_addr, ext_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b rd_en=%b wr_en=%b bank=%b, required all 0",
                     busy, store_done, buf_rd_en, ext_wr_en, buf_bank_sel);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            ext_wr_ready = 1'b1;
            @(negedge clk);
            if (store_done) n_done++;
            if (ext_wr_en || buf_rd_en) n_bad++;
        end
        @(posedge clk); #1;
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", n_done); end
        n_tests++; if (n_bad !== 0) begin n_fail++; $display("FAIL abort_activity: got %0d active cycles required 0", n_bad); end
        run_store(15'h0020, 16'h0040, 8'd4, 8'h00, 0, fw, lb, dc, nd, nr, nb, ba);
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL restart_done: got %0d required 1", nd); end
        n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL restart_missing: got %0d left required 0", sb.size()); end
        n_tests++; if (fw !== 3) begin n_fail++; $display("FAIL restart_first_wr: got %0d required 3", fw); end
        sb.delete();
    endtask

    initial begin
        store_enable = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        store_len    = '0;
        mem_sel      = '0;
        ext_wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_start_busy_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
